// File: rtl/i2n_frame_assembler_if.sv
// SPI-to-NITTA receive bundle: SPI subframe input plus assembled word output.
interface i2n_frame_assembler_if #(
  parameter int DATA_WIDTH      = 32,
  parameter int SPI_DATA_WIDTH  = 8,
  parameter int WORDS_PER_FRAME = 4
);
  localparam int IW = (WORDS_PER_FRAME > 1) ? $clog2(WORDS_PER_FRAME) : 1;

  logic                      spi_ready;
  logic [SPI_DATA_WIDTH-1:0] from_spi;
  logic                      spi_cs;
  logic                      word_valid;
  logic [DATA_WIDTH-1:0]     to_nitta;
  logic [IW-1:0]             word_index;
  logic                      frame_done;

  modport master (
    output spi_ready, from_spi, spi_cs,
    input  word_valid, to_nitta, word_index, frame_done
  );

  modport slave (
    input  spi_ready, from_spi, spi_cs,
    output word_valid, to_nitta, word_index, frame_done
  );
endinterface

// File: rtl/i2n_frame_assembler.sv
// SPI subframe to NITTA word/frame deserializer.
// Define I2N_FRAME_SYNC_EN to resynchronise on spi_cs deassertion.
module i2n_frame_assembler #(
  parameter int DATA_WIDTH      = 32,
  parameter int SPI_DATA_WIDTH  = 8,
  parameter int WORDS_PER_FRAME = 4,
  parameter bit MSB_FIRST       = 1'b1
) (
  input logic clk,
  input logic rst,
  i2n_frame_assembler_if.slave bus
);
  localparam int SUBFRAMES = DATA_WIDTH / SPI_DATA_WIDTH;
  localparam int SW = (SUBFRAMES > 1) ? $clog2(SUBFRAMES) : 1;
  localparam int IW = (WORDS_PER_FRAME > 1) ? $clog2(WORDS_PER_FRAME) : 1;
  localparam logic [SW-1:0] SUB_LAST  = SW'(SUBFRAMES - 1);
  localparam logic [IW-1:0] WORD_LAST = IW'(WORDS_PER_FRAME - 1);

  logic                  spi_ready_d;
  logic [DATA_WIDTH-1:0] acc;
  logic [DATA_WIDTH-1:0] acc_next;
  logic [SW-1:0]         sub_cnt;
  logic [IW-1:0]         word_cnt;
  logic                  accept;

  logic                  word_valid;
  logic [DATA_WIDTH-1:0] to_nitta;
  logic [IW-1:0]         word_index;
  logic                  frame_done;

  assign accept = bus.spi_ready & ~spi_ready_d;

  generate
    if (SUBFRAMES == 1) begin : g_single
      assign acc_next = bus.from_spi;
    end else if (MSB_FIRST) begin : g_msb
      assign acc_next = {acc[DATA_WIDTH-SPI_DATA_WIDTH-1:0], bus.from_spi};
    end else begin : g_lsb
      assign acc_next = {bus.from_spi, acc[DATA_WIDTH-1:SPI_DATA_WIDTH]};
    end
  endgenerate

`ifndef I2N_FRAME_SYNC_EN
  logic unused_cs;
  assign unused_cs = bus.spi_cs;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      spi_ready_d <= 1'b0;
      acc         <= '0;
      sub_cnt     <= '0;
      word_cnt    <= '0;
      word_valid  <= 1'b0;
      frame_done  <= 1'b0;
      to_nitta    <= '0;
      word_index  <= '0;
    end else begin
      spi_ready_d <= bus.spi_ready;
      word_valid  <= 1'b0;
      frame_done  <= 1'b0;
`ifdef I2N_FRAME_SYNC_EN
      if (!bus.spi_cs) begin
        acc      <= '0;
        sub_cnt  <= '0;
        word_cnt <= '0;
      end else
`endif
      if (accept) begin
        acc <= acc_next;
        if (sub_cnt == SUB_LAST) begin
          to_nitta   <= acc_next;
          word_index <= word_cnt;
          word_valid <= 1'b1;
          frame_done <= (word_cnt == WORD_LAST);
          sub_cnt    <= '0;
          word_cnt   <= (word_cnt == WORD_LAST) ? '0 : word_cnt + 1'b1;
        end else begin
          sub_cnt <= sub_cnt + 1'b1;
        end
      end
    end
  end

  assign bus.word_valid = word_valid;
  assign bus.to_nitta   = to_nitta;
  assign bus.word_index = word_index;
  assign bus.frame_done = frame_done;
endmodule
